edge_stage_sequencer: RTL and testbench
=======================================

# edge_stage_sequencer

Controls the edge-processing chain (sobel → edge_pixel_width → one_edge → color_contour) that shares a single dual-port edge BRAM. It starts each stage in order and grants that stage sole ownership of the edge BRAM ports. It also enforces a dead cycle between stages, runs a per-stage watchdog, and supports restart and abort without a global reset. It replaces the done-flag priority muxing in image_processing.

## Interface
- NUM_STAGES, 4, number of chained stages; stage 0 is sobel.
- TIMEOUT_CYCLES, 2_000_000, maximum cycles a stage may stay active before an error.
- TO_W, 21, watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.
- clk  in  1  single clock; all stages run in this domain.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to run the whole chain.
- abort  in  1  one-cycle request to stop the chain and return to IDLE.
- stage_start  out  NUM_STAGES  one-hot, one-cycle start pulse to stage k.
- stage_done  in  NUM_STAGES  done from stage k; level or pulse are both accepted.
- st_addr  in  NUM_STAGES*19  port-A address for each stage, flattened, stage k at [19k+:19].
- st_addrb  in  NUM_STAGES*19  port-B read address for each stage.
- st_din  in  NUM_STAGES*3  write data for each stage.
- st_we  in  NUM_STAGES  write enable for each stage.
- edge_bram_addr / edge_bram_addrb  out  19 each  muxed BRAM addresses.
- edge_bram_din  out  3  muxed write data.
- edge_bram_we  out  1  muxed write enable.
- active_stage  out  2  index of the stage that owns the BRAM.
- busy  out  1  high in RUN or GAP.
- done  out  1  level; high from chain completion until the next start, abort or reset.
- error  out  1  level; high after a watchdog timeout until the next start, abort or reset.

## Operation
- States: IDLE, RUN, GAP, DONE, ERR. The register stage_idx holds the current stage number.
- IDLE or DONE or ERR, start=1: go to RUN with stage_idx=0, pulse stage_start[0], clear done and error, clear the watchdog.
- RUN, stage_done[stage_idx]=1:
  - If stage_idx < NUM_STAGES-1: go to GAP.
  - If stage_idx is the last stage: go to DONE and set done=1.
- GAP lasts exactly one cycle. It then goes to RUN with stage_idx+1 and pulses stage_start[stage_idx+1] and clears the watchdog.
- RUN, watchdog reaches TIMEOUT_CYCLES-1 with no done: go to ERR, set error=1, keep stage_idx at the failing stage.
- abort in any state: go to IDLE, clear done and error. abort has priority over start and stage_done in the same cycle.
- start while in RUN or GAP is ignored; no re-trigger.
- stage_done for any stage other than stage_idx is ignored. Stage_done arriving in the same cycle as that stage's own start pulse is not sampled.
- Mux rules:
  - In RUN, all edge_bram outputs come from stage stage_idx.
  - In any other state, edge_bram_we=0 and both addresses and din are 0.
  - The mux is combinational on the registered state and stage_idx; there is no added latency.
- Reset values: state=IDLE, stage_idx=0, stage_start=0, done=0, error=0, busy=0, active_stage=0, edge_bram_we=0.

## Timing
- start sampled at edge t: RUN and stage_start[0] are visible after edge t; latency is 1 cycle.
- stage_done[k] sampled at edge t: GAP after t, RUN(k+1) and stage_start[k+1] after t+1. Between stages, port ownership and we are dropped for exactly one cycle.
- Last stage_done sampled at t: done=1 and busy=0 after t.
- Timeout: ERR is entered exactly TIMEOUT_CYCLES cycles after entering RUN for a stage.
- Reset asserted mid-run: outputs go to reset values immediately, because reset is asynchronous. We=0 with no glitch-through.

## Structure
- Package edge_seq_pkg holds:
  - the state enum;
  - NUM_STAGES;
  - the stage index constants SOBEL=0, ERODE=1, ONE_EDGE=2, COLOR=3;
  - the BRAM width constants ADDR_W=19 and DATA_W=3.
- The sub-module edge_port_mux contains the combinational ownership mux, given stage_idx and an enable. The FSM and watchdog stay in the top module.

## Test plan
- Stage k asserts done 10+k cycles after its start pulse. Expect:
  - start pulses in the order 0,1,2,3;
  - one GAP cycle with we=0 before each new start;
  - done=1 one cycle after the last done.
- Every stage holds we=1 with a distinct address. edge_bram_addr must match only the active stage's address; stage 2's we must never appear while stage 1 is active.
- TIMEOUT_CYCLES=50, stage 1 never finishes: expect ERR after exactly 50 RUN cycles, error=1, active_stage=1, we=0. Then start: error clears and the chain reruns from stage 0.
- abort and stage_done[2] in the same cycle: expect IDLE, no stage_start[3], done=0.
- Reset asserted during a stage-1 write: we=0 immediately, with no clock edge. After release the block is in IDLE and a new start runs the full chain.

Source files
------------

// File: rtl/edge_seq_pkg.sv
// Shared types and constants for the edge-processing chain sequencer.
package edge_seq_pkg;
  localparam int NUM_STAGES = 4;

  localparam int SOBEL    = 0;
  localparam int ERODE    = 1;
  localparam int ONE_EDGE = 2;
  localparam int COLOR    = 3;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE,
    S_ERR
  } seq_state_e;
endpackage

// File: rtl/edge_port_mux.sv
// Edge BRAM ownership mux: forwards the selected stage's port signals when enabled,
// otherwise drives an idle (all-zero, no-write) port.
module edge_port_mux #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic                             i_en,
  input  logic [IDX_W-1:0]                 i_sel,
  input  logic [N*edge_seq_pkg::ADDR_W-1:0] i_addr,
  input  logic [N*edge_seq_pkg::ADDR_W-1:0] i_addrb,
  input  logic [N*edge_seq_pkg::DATA_W-1:0] i_din,
  input  logic [N-1:0]                     i_we,
  output logic [edge_seq_pkg::ADDR_W-1:0]  o_addr,
  output logic [edge_seq_pkg::ADDR_W-1:0]  o_addrb,
  output logic [edge_seq_pkg::DATA_W-1:0]  o_din,
  output logic                             o_we
);
  import edge_seq_pkg::*;

  always_comb begin
    o_addr  = '0;
    o_addrb = '0;
    o_din   = '0;
    o_we    = 1'b0;
    if (i_en) begin
      o_addr  = i_addr[i_sel*ADDR_W +: ADDR_W];
      o_addrb = i_addrb[i_sel*ADDR_W +: ADDR_W];
      o_din   = i_din[i_sel*DATA_W +: DATA_W];
      o_we    = i_we[i_sel];
    end
  end
endmodule

// File: rtl/edge_stage_sequencer.sv
// Runs the sobel -> pixel_width -> one_edge -> color_contour chain in order, one dead
// cycle between stages, with a per-stage watchdog and abort/restart without reset.
module edge_stage_sequencer #(
  parameter int NUM_STAGES     = edge_seq_pkg::NUM_STAGES,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int TO_W           = 21,
  localparam int IDX_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      abort,
  output logic [NUM_STAGES-1:0]                     stage_start,
  input  logic [NUM_STAGES-1:0]                     stage_done,
  input  logic [NUM_STAGES*edge_seq_pkg::ADDR_W-1:0] st_addr,
  input  logic [NUM_STAGES*edge_seq_pkg::ADDR_W-1:0] st_addrb,
  input  logic [NUM_STAGES*edge_seq_pkg::DATA_W-1:0] st_din,
  input  logic [NUM_STAGES-1:0]                     st_we,
  output logic [edge_seq_pkg::ADDR_W-1:0]           edge_bram_addr,
  output logic [edge_seq_pkg::ADDR_W-1:0]           edge_bram_addrb,
  output logic [edge_seq_pkg::DATA_W-1:0]           edge_bram_din,
  output logic                                      edge_bram_we,
  output logic [IDX_W-1:0]                          active_stage,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      error
);
  import edge_seq_pkg::*;

  localparam logic [NUM_STAGES-1:0] START0 = NUM_STAGES'(1);

  seq_state_e             r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_STAGES-1:0]  r_stage_start;
  logic                   r_done;
  logic                   r_error;
  logic [TO_W-1:0]        r_wd;

  logic w_done_hit;
  logic w_last;
  logic w_timeout;

  // A done seen while the stage's own start pulse is still out is stale; skip it.
  assign w_done_hit = stage_done[r_idx] && !r_stage_start[r_idx];
  assign w_last     = (r_idx == IDX_W'(NUM_STAGES-1));
  assign w_timeout  = (r_wd == TO_W'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_stage_start <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_wd          <= '0;
    end else begin
      r_stage_start <= '0;
      if (abort) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
        r_done  <= 1'b0;
        r_error <= 1'b0;
        r_wd    <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
              r_state       <= S_RUN;
              r_idx         <= IDX_W'(SOBEL);
              r_stage_start <= START0;
              r_done        <= 1'b0;
              r_error       <= 1'b0;
              r_wd          <= '0;
            end
          end
          S_RUN: begin
            if (w_done_hit) begin
              if (w_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_GAP;
              end
            end else if (w_timeout) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else begin
              r_wd <= r_wd + 1'b1;
            end
          end
          S_GAP: begin
            r_state       <= S_RUN;
            r_idx         <= r_idx + 1'b1;
            r_stage_start <= START0 << (r_idx + 1'b1);
            r_wd          <= '0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign stage_start  = r_stage_start;
  assign done         = r_done;
  assign error        = r_error;
  assign active_stage = r_idx;
  assign busy         = (r_state == S_RUN) || (r_state == S_GAP);

  // Driven only from registered state, so an async reset drops we without an edge.
  edge_port_mux #(
    .N     (NUM_STAGES),
    .IDX_W (IDX_W)
  ) u_mux (
    .i_en    (r_state == S_RUN),
    .i_sel   (r_idx),
    .i_addr  (st_addr),
    .i_addrb (st_addrb),
    .i_din   (st_din),
    .i_we    (st_we),
    .o_addr  (edge_bram_addr),
    .o_addrb (edge_bram_addrb),
    .o_din   (edge_bram_din),
    .o_we    (edge_bram_we)
  );
endmodule

// File: tb/tb_edge_stage_sequencer.sv
// Bench for edge_stage_sequencer: random stage timing/port data against a timeline model.
module tb_edge_stage_sequencer;
  localparam int NS = 4;
  localparam int T  = 50;
  localparam int AW = 19;
  localparam int DW = 3;
  localparam int P_IDLE = 0, P_RUN = 1, P_GAP = 2, P_DONE = 3, P_ERR = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [NS-1:0]    stage_start;
  logic [NS-1:0]    stage_done = '0;
  logic [NS-1:0]    st_we = '0;
  logic [NS*AW-1:0] st_addr = '0;
  logic [NS*AW-1:0] st_addrb = '0;
  logic [NS*DW-1:0] st_din = '0;
  logic [AW-1:0]    edge_bram_addr, edge_bram_addrb;
  logic [DW-1:0]    edge_bram_din;
  logic             edge_bram_we;
  logic [1:0]       active_stage;
  logic             busy, done, error;

  int n_tests = 0;
  int n_fail  = 0;

  int dly[NS];
  bit lvl[NS];
  int s[NS];
  int hang, abort_at, rst_at, xstart_at;
  bit all_we;

  edge_stage_sequencer #(
    .NUM_STAGES(NS), .TIMEOUT_CYCLES(T), .TO_W(21)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .stage_start(stage_start), .stage_done(stage_done),
    .st_addr(st_addr), .st_addrb(st_addrb), .st_din(st_din), .st_we(st_we),
    .edge_bram_addr(edge_bram_addr), .edge_bram_addrb(edge_bram_addrb),
    .edge_bram_din(edge_bram_din), .edge_bram_we(edge_bram_we),
    .active_stage(active_stage), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc %0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  // Cycle c is the interval after the c-th edge following the start request edge.
  // Stage k is granted from s[k] to s[k]+dly[k]; one dead cycle follows.
  function automatic void plan();
    s[0] = 1;
    for (int i = 1; i < NS; i++) s[i] = s[i-1] + dly[i-1] + 2;
  endfunction

  task automatic model(input int c, output int ph, output int k);
    ph = P_DONE;
    k  = NS - 1;
    if (abort_at >= 0 && c > abort_at) begin
      ph = P_IDLE; k = 0; return;
    end
    for (int i = 0; i < NS; i++) begin
      if (i == hang) begin
        k = i; ph = (c < s[i] + T) ? P_RUN : P_ERR; return;
      end
      if (c <= s[i] + dly[i]) begin k = i; ph = P_RUN; return; end
      if (c == s[i] + dly[i] + 1 && i < NS - 1) begin k = i; ph = P_GAP; return; end
    end
  endtask

  task automatic idle_checks(input string tag, input int c);
    chk({tag, "_we"}, c, 32'(edge_bram_we), 32'd0);
    chk({tag, "_addr"}, c, 32'(edge_bram_addr), 32'd0);
    chk({tag, "_ss"}, c, 32'(stage_start), 32'd0);
    chk({tag, "_busy"}, c, 32'(busy), 32'd0);
    chk({tag, "_done"}, c, 32'(done), 32'd0);
    chk({tag, "_err"}, c, 32'(error), 32'd0);
    chk({tag, "_act"}, c, 32'(active_stage), 32'd0);
  endtask

  task automatic run_chain();
    int ph, k, last, ncyc;
    logic [AW-1:0] a[NS];
    logic [AW-1:0] b[NS];
    logic [DW-1:0] d[NS];
    logic [NS-1:0] w, sd, ess;
    bit            on;
    plan();
    last = (hang >= 0) ? s[hang] + T : s[NS-1] + dly[NS-1] + 1;
    ncyc = ((abort_at >= 0) ? abort_at : last) + 4;
    for (int c = 0; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (c == xstart_at);
      abort = (c == abort_at);
      sd = '0;
      for (int i = 0; i < NS; i++) begin
        a[i] = {i[1:0], 17'($urandom)};
        b[i] = AW'($urandom);
        d[i] = DW'($urandom);
        w[i] = all_we | 1'($urandom_range(0, 1));
        if (i != hang && c >= s[i] + dly[i] && (lvl[i] || c == s[i] + dly[i])) sd[i] = 1'b1;
        st_addr[i*AW +: AW]  = a[i];
        st_addrb[i*AW +: AW] = b[i];
        st_din[i*DW +: DW]   = d[i];
      end
      stage_done = sd;
      st_we      = w;
      if (c == 0) continue;
      @(negedge clk);
      model(c, ph, k);
      on  = (ph == P_RUN);
      ess = (on && c == s[k]) ? (NS'(1) << k) : '0;
      chk("stage_start", c, 32'(stage_start), 32'(ess));
      chk("we", c, 32'(edge_bram_we), on ? 32'(w[k]) : 32'd0);
      chk("addr", c, 32'(edge_bram_addr), on ? 32'(a[k]) : 32'd0);
      chk("addrb", c, 32'(edge_bram_addrb), on ? 32'(b[k]) : 32'd0);
      chk("din", c, 32'(edge_bram_din), on ? 32'(d[k]) : 32'd0);
      chk("busy", c, 32'(busy), 32'(ph == P_RUN || ph == P_GAP));
      chk("done", c, 32'(done), 32'(ph == P_DONE));
      chk("error", c, 32'(error), 32'(ph == P_ERR));
      if (ph != P_IDLE) chk("active_stage", c, 32'(active_stage), 32'(k));
      if (c == rst_at) begin
        #1 reset = 1'b1;
        #1 idle_checks("async_rst", c);
        start = 1'b0; abort = 1'b0; stage_done = '0;
        return;
      end
    end
    start = 1'b0; abort = 1'b0; stage_done = '0;
  endtask

  task automatic defaults(input bit directed);
    hang = -1; abort_at = -1; rst_at = -1; xstart_at = -1; all_we = directed;
    for (int i = 0; i < NS; i++) begin
      dly[i] = directed ? 10 + i : $urandom_range(1, 20);
      lvl[i] = directed ? 1'b0 : 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #1 idle_checks("reset", -1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Nominal chain, stage k done 10+k cycles after its start, all stages writing.
    defaults(1'b1);
    run_chain();

    // Stage 1 hangs: watchdog error after T run cycles.
    defaults(1'b1);
    hang = 1;
    run_chain();

    // Restart out of ERR, then random timing with stray starts while busy.
    for (int r = 0; r < 5; r++) begin
      defaults(1'b0);
      plan();
      if (r > 0) xstart_at = $urandom_range(2, s[NS-1] + dly[NS-1]);
      run_chain();
    end

    // Abort in the same cycle as stage 2's done.
    defaults(1'b1);
    plan();
    abort_at = s[2] + dly[2];
    run_chain();

    // Abort while DONE clears done.
    defaults(1'b0);
    plan();
    abort_at = s[NS-1] + dly[NS-1] + 3;
    run_chain();

    // Async reset during a stage-1 write, then a full chain afterwards.
    defaults(1'b1);
    plan();
    rst_at = s[1] + 3;
    run_chain();
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) idle_checks("post_rst", 0);
    defaults(1'b0);
    run_chain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
